// File: rtl/demux_sched.sv
// demux_sched: sequences the 1-to-8 demux select/enable lines through the
// channels set in a latched mask, ascending, with a programmable dwell per
// slot and a one-cycle break-before-make gap between slots.
module demux_sched #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               enable,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDwell = 2'd1;
    localparam logic [1:0] StGap   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               mode_q, mode_d;
    logic [2:0]         sel_q, sel_d;
    logic               enable_q, enable_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               next_found;
    logic [2:0]         next_ch;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Lowest enabled channel strictly above the current select (none = wrap point).
    always_comb begin
        next_found = 1'b0;
        next_ch    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(sel_q))) begin
                next_found = 1'b1;
                next_ch    = 3'(i);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        dwell_d  = dwell_q;
        mode_d   = mode_q;
        sel_d    = sel_q;
        enable_d = enable_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // stop takes priority over start, including suppressing err
                if (start && !stop) begin
                    if (mask != 8'd0) begin
                        mask_d   = mask;
                        dwell_d  = dwell;
                        mode_d   = mode;
                        sel_d    = lowest_set(mask);
                        enable_d = 1'b1;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        state_d  = StDwell;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StDwell: begin
                if (stop) begin
                    enable_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end else if (cnt_q == dwell_q) begin
                    // compare before increment so dwell at max never wraps early
                    enable_d = 1'b0;
                    if (next_found) begin
                        sel_d   = next_ch;
                        state_d = StGap;
                    end else if (!mode_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        sel_d   = lowest_set(mask_q);
                        done_d  = 1'b1;
                        state_d = StGap;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            StGap: begin
                if (stop) begin
                    enable_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end else begin
                    enable_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = StDwell;
                end
            end
            default: begin
                enable_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mask_q   <= '0;
            dwell_q  <= '0;
            mode_q   <= 1'b0;
            sel_q    <= 3'd0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            dwell_q  <= dwell_d;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign sel    = sel_q;
    assign enable = enable_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_demux_sched.sv
// tb_demux_sched: directed vector table plus hand-written multi-cycle
// sequences for demux_sched.
module tb_demux_sched;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       enable;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    demux_sched #(.DWELL_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .mask   (mask),
        .dwell  (dwell),
        .sel    (sel),
        .enable (enable),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row: inputs held across an edge, expected outputs in the following cycle.
    typedef struct {
        string      name;
        logic       start;
        logic       stop;
        logic       mode;
        logic [7:0] mask;
        logic [7:0] dwell;
        logic [6:0] exp; // {sel, enable, busy, done, err}
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic st, input logic sp, input logic md,
                       input logic [7:0] mk, input logic [7:0] dw, input logic [2:0] es,
                       input logic ee, input logic eb, input logic ed, input logic er);
        vec_t v;
        v.name  = nm;
        v.start = st;
        v.stop  = sp;
        v.mode  = md;
        v.mask  = mk;
        v.dwell = dw;
        v.exp   = {es, ee, eb, ed, er};
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [6:0] exp);
        logic [6:0] act;
        act = {sel, enable, busy, done, err};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {sel,en,busy,done,err}=%b want %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int en_cnt;
    int cyc;
    logic seen_done;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 1'b0;
        mask  = 8'h00;
        dwell = 8'd0;

        // Single sweep, mask 0x25, dwell 2
        add("sw0_c1",  1, 0, 0, 8'h25, 8'd2, 3'd0, 1, 1, 0, 0);
        add("sw0_c2",  0, 0, 0, 8'h25, 8'd2, 3'd0, 1, 1, 0, 0);
        add("sw0_c3",  0, 0, 0, 8'h25, 8'd2, 3'd0, 1, 1, 0, 0);
        add("sw_gap2", 0, 0, 0, 8'h25, 8'd2, 3'd2, 0, 1, 0, 0);
        add("sw2_c5",  0, 0, 0, 8'h25, 8'd2, 3'd2, 1, 1, 0, 0);
        add("sw2_c6",  0, 0, 0, 8'h25, 8'd2, 3'd2, 1, 1, 0, 0);
        add("sw2_c7",  0, 0, 0, 8'h25, 8'd2, 3'd2, 1, 1, 0, 0);
        add("sw_gap5", 0, 0, 0, 8'h25, 8'd2, 3'd5, 0, 1, 0, 0);
        add("sw5_c9",  0, 0, 0, 8'h25, 8'd2, 3'd5, 1, 1, 0, 0);
        add("sw5_c10", 0, 0, 0, 8'h25, 8'd2, 3'd5, 1, 1, 0, 0);
        add("sw5_c11", 0, 0, 0, 8'h25, 8'd2, 3'd5, 1, 1, 0, 0);
        add("sw_done", 0, 0, 0, 8'h25, 8'd2, 3'd5, 0, 0, 1, 0);
        add("sw_idle", 0, 0, 0, 8'h25, 8'd2, 3'd5, 0, 0, 0, 0);
        // Empty mask, then start+stop together
        add("err_pls", 1, 0, 0, 8'h00, 8'd2, 3'd5, 0, 0, 0, 1);
        add("err_clr", 0, 0, 0, 8'h00, 8'd2, 3'd5, 0, 0, 0, 0);
        add("stst_0",  1, 1, 0, 8'hFF, 8'd2, 3'd5, 0, 0, 0, 0);
        add("stst_1",  0, 0, 0, 8'hFF, 8'd2, 3'd5, 0, 0, 0, 0);
        // mask 0x03, dwell 4; start with new mask during the sweep is ignored
        add("ign_c1",  1, 0, 0, 8'h03, 8'd4, 3'd0, 1, 1, 0, 0);
        add("ign_c2",  0, 0, 0, 8'h03, 8'd4, 3'd0, 1, 1, 0, 0);
        add("ign_c3",  1, 0, 0, 8'hF0, 8'd1, 3'd0, 1, 1, 0, 0);
        add("ign_c4",  0, 0, 0, 8'hF0, 8'd1, 3'd0, 1, 1, 0, 0);
        add("ign_c5",  0, 0, 0, 8'hF0, 8'd1, 3'd0, 1, 1, 0, 0);
        add("ign_gap", 0, 0, 0, 8'hF0, 8'd1, 3'd1, 0, 1, 0, 0);
        add("ign_c7",  0, 0, 0, 8'hF0, 8'd1, 3'd1, 1, 1, 0, 0);
        add("ign_c8",  0, 0, 0, 8'hF0, 8'd1, 3'd1, 1, 1, 0, 0);
        add("ign_c9",  0, 0, 0, 8'hF0, 8'd1, 3'd1, 1, 1, 0, 0);
        add("ign_c10", 0, 0, 0, 8'hF0, 8'd1, 3'd1, 1, 1, 0, 0);
        add("ign_c11", 0, 0, 0, 8'hF0, 8'd1, 3'd1, 1, 1, 0, 0);
        add("ign_done",0, 0, 0, 8'hF0, 8'd1, 3'd1, 0, 0, 1, 0);

        #1;
        chk("reset", 7'b000_0000);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_reset_idle", 7'b000_0000);

        foreach (tbl[i]) begin
            start = tbl[i].start;
            stop  = tbl[i].stop;
            mode  = tbl[i].mode;
            mask  = tbl[i].mask;
            dwell = tbl[i].dwell;
            step();
            chk(tbl[i].name, tbl[i].exp);
        end
        start = 1'b0;
        stop  = 1'b0;

        // Continuous, single channel 7, dwell 0
        start = 1'b1; mode = 1'b1; mask = 8'h80; dwell = 8'd0;
        step();
        start = 1'b0;
        chk("cont_first", {3'd7, 4'b1100});
        for (int k = 0; k < 3; k++) begin
            step();
            chk("cont_gap", {3'd7, 4'b0110});
            step();
            chk("cont_slot", {3'd7, 4'b1100});
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("cont_stop", {3'd7, 4'b0000});
        for (int k = 0; k < 3; k++) begin
            step();
            chk("cont_after_stop", {3'd7, 4'b0000});
        end

        // Asynchronous reset mid-slot
        start = 1'b1; mode = 1'b0; mask = 8'hFF; dwell = 8'd7;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("rst_pre", {3'd0, 4'b1100});
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", 7'b000_0000);
        step();
        #2;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_stay_idle", 7'b000_0000);
        end

        // Maximum dwell: slot must be 256 cycles
        start = 1'b1; mode = 1'b0; mask = 8'h01; dwell = 8'd255;
        step();
        start = 1'b0;
        en_cnt    = 0;
        seen_done = 1'b0;
        cyc       = 0;
        while (!seen_done && cyc < 400) begin
            if (enable) en_cnt++;
            if (done) begin
                seen_done = 1'b1;
                chk("maxdw_done", {3'd0, 4'b0010});
            end else begin
                step();
                cyc++;
            end
        end
        checks++;
        if (!seen_done || en_cnt != 256) begin
            errors++;
            $display("FAIL maxdw_len: got enable cycles=%0d done_seen=%0b want 256 and 1",
                     en_cnt, seen_done);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
